// File: rtl/rv32i_types.sv
// Shared CPU types used by the performance counter bank.
// Holds the counter offset map, bank sizing constants and the responder FSM
// state encoding. The optional control register (macro PERF_COUNTER_CTRL_EN)
// sits at PERF_CTRL_OFFSET.
package rv32i_types;

    // Byte offsets of each counter inside the perf window (single source of truth)
    typedef enum logic [7:0] {
        icache_hit        = 8'h00,
        icache_miss       = 8'h04,
        dcache_hit        = 8'h08,
        dcache_miss       = 8'h0C,
        l2_hit            = 8'h10,
        l2_miss           = 8'h14,
        ewb_write         = 8'h18,
        branch_total      = 8'h1C,
        branch_mispredict = 8'h20,
        prefetch_issue    = 8'h24,
        prefetch_read     = 8'h28
    } counter_addr;

    localparam int unsigned PERF_NUM_COUNTERS = 11;
    localparam logic [7:0]  PERF_CTRL_OFFSET  = 8'h2C;

    // Responder FSM encoding
    typedef logic [1:0] perf_state_t;
    localparam perf_state_t IDLE = 2'd0;
    localparam perf_state_t RESP = 2'd1;
    localparam perf_state_t DONE = 2'd2;

endpackage

// File: rtl/perf_counter.sv
// Single event counter with byte-enabled load and synchronous clear.
// Priority: clear > load > inc; increment wraps at the top of the range.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   inc        count one event this cycle
//   load       load lanes selected by be from wdata
//   be         byte lanes for load
//   wdata      load data
//   clear      zero the counter
//   count      current value
module perf_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               load,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               clear,
    output logic [WIDTH-1:0]   count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            for (int b = 0; b < int'(WIDTH / 8); b++) begin
                if (be[b]) count[b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of CPU performance counters on the data-memory port.
// Optional control register (freeze / clear) enabled by PERF_COUNTER_CTRL_EN.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mem_address       byte address from CPU data port
//   mem_read/write    held requests, completed by mem_resp
//   mem_wdata, mem_byte_enable  write data and lanes
//   mem_rdata         read data, valid while mem_resp=1
//   mem_resp          one-cycle completion pulse
//   sel               combinational window decode for the CPU data mux
//   events            one-cycle event pulses, bit i -> counter at offset 4*i
module perf_counter_bank
    import rv32i_types::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
    parameter int unsigned NUM_COUNTERS = PERF_NUM_COUNTERS,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             mem_address,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_byte_enable,
    output logic [31:0]             mem_rdata,
    output logic                    mem_resp,
    output logic                    sel,
    input  logic [NUM_COUNTERS-1:0] events
);

    perf_state_t state, state_next;
    logic        resp_next;
    logic [31:0] rdata_next;
    logic [31:0] rd_word;

    logic [7:0] offset;
    logic [5:0] idx;
    logic       aligned, cnt_hit, req, capture, wr_en;
    logic       freeze, clear_all;

    logic [NUM_COUNTERS-1:0] load;
    logic [NUM_COUNTERS-1:0] inc;
    logic [CNT_WIDTH-1:0]    cnt [NUM_COUNTERS];

    // Address decode
    assign sel     = (mem_address[31:8] == BASE_ADDR[31:8]);
    assign offset  = mem_address[7:0];
    assign idx     = offset[7:2];
    assign aligned = (offset[1:0] == 2'b00);
    assign cnt_hit = aligned && (32'(idx) < NUM_COUNTERS);
    assign req     = sel && (mem_read || mem_write);
    assign capture = (state == IDLE) && req;
    // Read wins when both strobes are set
    assign wr_en   = capture && !mem_read;

`ifdef PERF_COUNTER_CTRL_EN
    logic ctrl_wr;
    assign ctrl_wr   = wr_en && (offset == PERF_CTRL_OFFSET) && mem_byte_enable[0];
    // Clear is a write-side pulse only; it is never stored
    assign clear_all = ctrl_wr && mem_wdata[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          freeze <= 1'b0;
        else if (ctrl_wr) freeze <= mem_wdata[0];
    end
`else
    assign freeze    = 1'b0;
    assign clear_all = 1'b0;
`endif

    // Counter array
    for (genvar i = 0; i < int'(NUM_COUNTERS); i++) begin : g_cnt
        assign load[i] = wr_en && cnt_hit && (idx == 6'(i));
        assign inc[i]  = events[i] && !freeze;

        perf_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc[i]),
            .load  (load[i]),
            .be    (mem_byte_enable),
            .wdata (mem_wdata),
            .clear (clear_all),
            .count (cnt[i])
        );
    end

    // Read mux: pre-increment value of the addressed counter, 0 on miss
    always_comb begin
        rd_word = '0;
        if (cnt_hit) begin
            for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
                if (idx == 6'(i)) rd_word = cnt[i];
            end
        end
`ifdef PERF_COUNTER_CTRL_EN
        if (aligned && offset == PERF_CTRL_OFFSET) rd_word = {31'b0, freeze};
`endif
    end

    // FSM state register and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
        end else begin
            state     <= state_next;
            mem_resp  <= resp_next;
            mem_rdata <= rdata_next;
        end
    end

    // Next state; DONE gives the requester a cycle to drop a held request
    always_comb begin
        state_next = state;
        resp_next  = 1'b0;
        rdata_next = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = RESP;
                    resp_next  = 1'b1;
                    rdata_next = mem_read ? rd_word : 32'h0;
                end
            end
            RESP:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule
